// File: rtl/hex_display_arbiter_pkg.sv
// Shared types and constants for the HEX display arbiter: FSM states,
// owner codes, register map and the blank segment pattern.
package hex_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HPS_OWN = 2'd1,
    FAB_OWN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_HPS  = 2'd1,
    OWNER_FAB  = 2'd2
  } owner_e;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_LEASE  = 2'd3;

  // Segments are active-low, so all ones turns every segment off.
  localparam int                   SEG_W_STD = 21;
  localparam logic [SEG_W_STD-1:0] SEG_BLANK = '1;

  // Owner code reported in STATUS for a given FSM state.
  function automatic owner_e owner_of(input state_e s);
    owner_e o;
    case (s)
      HPS_OWN: o = OWNER_HPS;
      FAB_OWN: o = OWNER_FAB;
      default: o = OWNER_NONE;
    endcase
    return o;
  endfunction

  // A zero lease would never count, so it is stored as one cycle.
  function automatic logic [31:0] lease_value(input logic [31:0] wd);
    return (wd == 32'd0) ? 32'd1 : wd;
  endfunction

endpackage

// File: rtl/hex_display_arbiter_if.sv
// Avalon-MM register port of the HEX display arbiter.
interface hex_display_arbiter_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;

  modport master (output address, write, writedata, read, input readdata);
  modport slave  (input address, write, writedata, read, output readdata);
endinterface

// File: rtl/hex_display_arbiter_csr.sv
// Avalon register file (HPS_DATA, CTRL, LEASE) and registered readdata mux.
module hex_arb_csr
  import hex_arb_pkg::*;
#(
  parameter int          SEG_W         = 21,
  parameter logic [31:0] LEASE_DEFAULT = 32'd50_000_000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  hex_display_arbiter_if.slave  avs,
  input  owner_e                owner,
  input  logic                  fab_req,
  input  logic                  lease_expired,
  output logic [SEG_W-1:0]      hps_data,
  output logic                  hps_en,
  output logic                  blank,
  output logic [31:0]           lease
);

  logic [31:0] rd_next;

  // readdata is refreshed every cycle, so the read strobe carries no information.
  logic unused_read;
  assign unused_read = avs.read;

  // Register writes land on the clock edge of the write strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      hps_data <= '1;
      hps_en   <= 1'b0;
      blank    <= 1'b0;
      lease    <= LEASE_DEFAULT;
    end else if (avs.write) begin
      case (avs.address)
        ADDR_DATA:  hps_data <= avs.writedata[SEG_W-1:0];
        ADDR_CTRL: begin
          hps_en <= avs.writedata[0];
          blank  <= avs.writedata[1];
        end
        ADDR_LEASE: lease <= lease_value(avs.writedata);
        default:    ;
      endcase
    end
  end

  // Read mux; unused bits read as zero.
  always_comb begin
    rd_next = '0;
    case (avs.address)
      ADDR_DATA:   rd_next = 32'(hps_data);
      ADDR_CTRL:   rd_next = {30'd0, blank, hps_en};
      ADDR_STATUS: rd_next = {28'd0, lease_expired, fab_req, owner};
      ADDR_LEASE:  rd_next = lease;
      default:     rd_next = '0;
    endcase
  end

  // Readdata register: valid one cycle after the address is presented.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) avs.readdata <= '0;
    else          avs.readdata <= rd_next;
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Shares the HEX digits between the HPS and one fabric requester using a
// leased, round-robin ownership FSM and a registered segment bus.
module hex_display_arbiter
  import hex_arb_pkg::*;
#(
  parameter int          NUM_DIGITS    = 3,
  parameter logic [31:0] LEASE_DEFAULT = 32'd50_000_000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  hex_display_arbiter_if.slave    avs,
  input  logic                    fab_req,
  input  logic [7*NUM_DIGITS-1:0] fab_data,
  output logic                    fab_grant,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int SEG_W = 7 * NUM_DIGITS;

  state_e           state, next_state;
  owner_e           last_owner;
  logic [31:0]      lease_cnt, lease;
  logic [SEG_W-1:0] hps_data, hex_next;
  logic             fab_req_q, hps_en, blank, lease_expired, grant;

  assign lease_expired = (state != IDLE) && (lease_cnt == 32'd0);

  hex_arb_csr #(
    .SEG_W         (SEG_W),
    .LEASE_DEFAULT (LEASE_DEFAULT)
  ) u_csr (
    .clk           (clk),
    .reset_n       (reset_n),
    .avs           (avs),
    .owner         (owner_of(state)),
    .fab_req       (fab_req_q),
    .lease_expired (lease_expired),
    .hps_data      (hps_data),
    .hps_en        (hps_en),
    .blank         (blank),
    .lease         (lease)
  );

  // Next ownership: round-robin tie-break in IDLE, switch only after expiry.
  always_comb begin
    // NOTE: defaults assigned first keep every path covered, so no latch is inferred.
    next_state = state;
    case (state)
      IDLE: begin
        if (hps_en && fab_req_q)
          next_state = (last_owner == OWNER_HPS) ? FAB_OWN : HPS_OWN;
        else if (hps_en)
          next_state = HPS_OWN;
        else if (fab_req_q)
          next_state = FAB_OWN;
      end
      HPS_OWN: begin
        if (!hps_en)                       next_state = IDLE;
        else if (lease_expired && fab_req_q) next_state = FAB_OWN;
      end
      FAB_OWN: begin
        if (!fab_req_q)                    next_state = IDLE;
        else if (lease_expired && hps_en)  next_state = HPS_OWN;
      end
      default: next_state = IDLE;
    endcase
    grant = (next_state != IDLE) && (next_state != state);
  end

  // Display source for the next cycle; blank overrides without touching arbitration.
  always_comb begin
    hex_next = '1;
    if (!blank) begin
      case (state)
        HPS_OWN: hex_next = hps_data;
        FAB_OWN: hex_next = fab_data;
        default: hex_next = '1;
      endcase
    end
  end

  // Ownership state, lease counter, grant and segment output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_owner <= OWNER_FAB;
      lease_cnt  <= 32'd0;
      fab_req_q  <= 1'b0;
      fab_grant  <= 1'b0;
      hex_out    <= '1;
    end else begin
      // Registering the request gives both requesters the same one-cycle latency.
      fab_req_q <= fab_req;
      state     <= next_state;
      fab_grant <= (next_state == FAB_OWN);
      hex_out   <= hex_next;
      if (grant) begin
        lease_cnt  <= lease;
        last_owner <= owner_of(next_state);
      end else if (state != IDLE && lease_cnt != 32'd0) begin
        lease_cnt <= lease_cnt - 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with a 4-cycle default lease.
module tb_hex_display_arbiter;
  import hex_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fab_req;
  logic [20:0] fab_data;
  logic        fab_grant;
  logic [20:0] hex_out;
  logic [31:0] rd;
  int          checks = 0;
  int          errors = 0;

  hex_display_arbiter_if av();

  hex_display_arbiter #(
    .NUM_DIGITS    (3),
    .LEASE_DEFAULT (32'd4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .avs       (av.slave),
    .fab_req   (fab_req),
    .fab_data  (fab_data),
    .fab_grant (fab_grant),
    .hex_out   (hex_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  typedef struct {
    logic [20:0] pattern;
    logic [20:0] exp;
  } seg_vec_t;

  reg_vec_t reg_tab [8];
  seg_vec_t seg_tab [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    av.address   = a;
    av.writedata = d;
    av.write     = 1'b1;
    tick();
    av.write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    av.address = a;
    tick();
    d = av.readdata;
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    fab_req      = 1'b0;
    fab_data     = '0;
    av.address   = '0;
    av.write     = 1'b0;
    av.writedata = '0;
    av.read      = 1'b0;
    #12;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reg_tab[0] = '{ADDR_DATA,   32'hFFFF_FFFF, 32'h001F_FFFF};
    reg_tab[1] = '{ADDR_DATA,   32'h1234_5678, 32'h0014_5678};
    reg_tab[2] = '{ADDR_CTRL,   32'hFFFF_FFFC, 32'h0000_0000};
    reg_tab[3] = '{ADDR_CTRL,   32'h0000_0002, 32'h0000_0002};
    reg_tab[4] = '{ADDR_LEASE,  32'h0000_0000, 32'h0000_0001};
    reg_tab[5] = '{ADDR_LEASE,  32'h0000_0007, 32'h0000_0007};
    reg_tab[6] = '{ADDR_LEASE,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    reg_tab[7] = '{ADDR_STATUS, 32'h0000_000F, 32'h0000_0000};

    seg_tab[0] = '{21'h000000, 21'h000000};
    seg_tab[1] = '{21'h1FFFFF, 21'h1FFFFF};
    seg_tab[2] = '{21'h155555, 21'h155555};
    seg_tab[3] = '{21'h0AAAAA, 21'h0AAAAA};
    seg_tab[4] = '{21'h07F00F, 21'h07F00F};

    // Reset state, no writes.
    do_reset();
    check("rst_hex", 32'(hex_out), 32'(SEG_BLANK));
    check("rst_grant", 32'(fab_grant), 32'd0);
    bus_read(ADDR_STATUS, rd);
    check("rst_status", rd, 32'h0);
    bus_read(ADDR_DATA, rd);
    check("rst_data", rd, 32'h001F_FFFF);
    bus_read(ADDR_LEASE, rd);
    check("rst_lease", rd, 32'd4);

    // HPS takes the display: owner one cycle after CTRL write, segments one after that.
    bus_write(ADDR_DATA, 32'h0004_0079);
    bus_write(ADDR_CTRL, 32'h1);
    av.address = ADDR_STATUS;
    tick();
    check("hps_hex_pre", 32'(hex_out), 32'h001F_FFFF);
    check("hps_status_pre", av.readdata, 32'h0);
    tick();
    check("hps_hex", 32'(hex_out), 32'h0004_0079);
    check("hps_status", av.readdata, 32'h1);

    // Tie from reset: HPS first, fabric takes over once the lease expires.
    do_reset();
    bus_write(ADDR_DATA, 32'h0000_0F0F);
    fab_data     = 21'h0A5A5A;
    av.address   = ADDR_CTRL;
    av.writedata = 32'h1;
    av.write     = 1'b1;
    fab_req      = 1'b1;
    tick();
    av.write   = 1'b0;
    av.address = ADDR_STATUS;
    tick();
    check("tie_status_req", av.readdata, 32'h4);
    check("tie_grant0", 32'(fab_grant), 32'd0);
    tick();
    check("tie_status_hps", av.readdata, 32'h5);
    check("tie_hex_hps", 32'(hex_out), 32'h0000_0F0F);
    tick(3);
    check("tie_no_preempt", 32'(fab_grant), 32'd0);
    check("tie_status_cnt1", av.readdata, 32'h5);
    tick();
    check("tie_fab_grant", 32'(fab_grant), 32'd1);
    check("tie_status_expired", av.readdata, 32'hD);
    check("tie_hex_still_hps", 32'(hex_out), 32'h0000_0F0F);
    tick();
    check("tie_hex_fab", 32'(hex_out), 32'h000A_5A5A);
    check("tie_status_fab", av.readdata, 32'h6);

    // Fabric keeps the display alone; data passes through with one cycle latency.
    bus_write(ADDR_CTRL, 32'h0);
    for (int i = 0; i < 5; i++) begin
      fab_data = seg_tab[i].pattern;
      tick();
      check($sformatf("fab_data_%0d", i), 32'(hex_out), 32'(seg_tab[i].exp));
    end
    av.address = ADDR_STATUS;
    tick(6);
    check("fab_hold_status", av.readdata, 32'hE);
    check("fab_hold_grant", 32'(fab_grant), 32'd1);

    // Blank forces segments off but fabric keeps ownership.
    bus_write(ADDR_CTRL, 32'h2);
    tick();
    check("blank_hex", 32'(hex_out), 32'h001F_FFFF);
    check("blank_grant", 32'(fab_grant), 32'd1);

    // Release and competing HPS request together: IDLE first, HPS a cycle later.
    fab_data     = 21'h07F00F;
    av.address   = ADDR_CTRL;
    av.writedata = 32'h1;
    av.write     = 1'b1;
    fab_req      = 1'b0;
    tick();
    av.write   = 1'b0;
    av.address = ADDR_STATUS;
    tick();
    check("rel_grant", 32'(fab_grant), 32'd0);
    check("rel_hex_last_fab", 32'(hex_out), 32'h0007_F00F);
    check("rel_status_fab", av.readdata, 32'hA);
    tick();
    check("rel_hex_idle", 32'(hex_out), 32'h001F_FFFF);
    check("rel_status_idle", av.readdata, 32'h0);
    tick();
    check("rel_hex_hps", 32'(hex_out), 32'h0000_0F0F);
    check("rel_status_hps", av.readdata, 32'h1);

    // Blank while HPS owns: segments off, owner unchanged.
    bus_write(ADDR_CTRL, 32'h3);
    tick();
    check("hps_blank_hex", 32'(hex_out), 32'h001F_FFFF);
    bus_read(ADDR_STATUS, rd);
    check("hps_blank_owner", rd & 32'h3, 32'h1);

    // Register write/readback table.
    for (int i = 0; i < 8; i++) begin
      bus_write(reg_tab[i].addr, reg_tab[i].wdata);
      bus_read(reg_tab[i].addr, rd);
      check($sformatf("reg_%0d", i), rd, reg_tab[i].exp);
    end

    // Asynchronous reset during fabric ownership, then a fresh tie.
    do_reset();
    fab_data = 21'h1C0C0C;
    fab_req  = 1'b1;
    tick(2);
    check("ar_grant", 32'(fab_grant), 32'd1);
    tick();
    check("ar_hex", 32'(hex_out), 32'h001C_0C0C);
    #3;
    reset_n = 1'b0;
    #1;
    check("ar_grant_async", 32'(fab_grant), 32'd0);
    check("ar_hex_async", 32'(hex_out), 32'h001F_FFFF);
    @(negedge clk);
    reset_n = 1'b1;
    bus_write(ADDR_CTRL, 32'h1);
    av.address = ADDR_STATUS;
    tick();
    check("ar_tie_grant", 32'(fab_grant), 32'd0);
    check("ar_tie_status_req", av.readdata, 32'h4);
    tick();
    check("ar_tie_status_hps", av.readdata, 32'h5);
    check("ar_tie_hex", 32'(hex_out), 32'h001F_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
